// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
//   Shared definitions for the LED comet sequencer: channel count, duty word
//   geometry, the frame-builder FSM encoding, the head-advance rule and the
//   helpers that move a frame between its per-channel form and the flat bus.
//
//   Contents
//     NUM_LEDS, DUTY_W, DUTY_MAX, HEAD_W   geometry constants
//     duty_t, head_t, frame_t, flat_t      per-channel / per-frame types
//     state_e                              IDLE -> DECAY -> HEAD -> PUBLISH
//     head_step_t, next_head()             one step of head movement
//     pack_frame(), unpack_frame()         frame_t <-> flat duty bus
// -----------------------------------------------------------------------------
package led_pkg;

  localparam int NUM_LEDS = 26;  // LEDR[17:0] + LEDG[7:0]
  localparam int DUTY_W   = 8;
  localparam int HEAD_W   = $clog2(NUM_LEDS);

  typedef logic [DUTY_W-1:0]                 duty_t;
  typedef logic [HEAD_W-1:0]                 head_t;
  typedef logic [NUM_LEDS-1:0][DUTY_W-1:0]   frame_t;
  typedef logic [NUM_LEDS*DUTY_W-1:0]        flat_t;

  localparam duty_t DUTY_MAX  = '1;
  localparam head_t HEAD_LAST = head_t'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECAY,
    ST_HEAD,
    ST_PUBLISH
  } state_e;

  typedef struct packed {
    head_t head;
    logic  dir_down;
  } head_step_t;

  // One animation step of head movement. With wrap enabled the head always
  // travels upwards, so a pending downward direction is cancelled here.
  function automatic head_step_t next_head(input head_t head,
                                           input logic  dir_down,
                                           input logic  wrap);
    head_step_t r;
    r.head     = head;
    r.dir_down = dir_down;
    if (wrap || !dir_down) begin
      r.dir_down = 1'b0;
      if (head == HEAD_LAST) begin
        if (wrap) begin
          r.head = '0;
        end else begin
          r.head     = HEAD_LAST - head_t'(1);
          r.dir_down = 1'b1;
        end
      end else begin
        r.head = head + head_t'(1);
      end
    end else begin
      if (head == '0) begin
        r.head     = head_t'(1);
        r.dir_down = 1'b0;
      end else begin
        r.head = head - head_t'(1);
      end
    end
    return r;
  endfunction

  // Channel i lives at flat[i*DUTY_W +: DUTY_W].
  function automatic flat_t pack_frame(input frame_t f);
    flat_t p;
    p = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      p[i*DUTY_W +: DUTY_W] = f[i];
    end
    return p;
  endfunction

  function automatic frame_t unpack_frame(input flat_t p);
    frame_t f;
    f = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      f[i] = p[i*DUTY_W +: DUTY_W];
    end
    return f;
  endfunction

endpackage

// File: rtl/step_divider.sv
// -----------------------------------------------------------------------------
// step_divider
//   Animation-step prescaler. Counts 0..STEP_DIV-1 while enabled and emits a
//   single-cycle tick in the cycle the count sits at its terminal value. The
//   count freezes (and no tick is produced) while enable_i is low.
//
//   Ports
//     clk_i     in   sole clock
//     rst_i     in   synchronous active-high reset, clears the count
//     enable_i  in   1 = count, 0 = hold
//     tick_o    out  1-cycle step request
// -----------------------------------------------------------------------------
module step_divider #(
  parameter int STEP_DIV = 2500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick_o = enable_i && (count_q == CNT_LAST);

  // NOTE: count_d gets a default before any branch so every path assigns it;
  // without that the synthesiser would infer a latch to hold the old value.
  always_comb begin
    count_d = count_q;
    if (enable_i) begin
      count_d = tick_o ? '0 : count_q + CNT_W'(1);
    end
  end

  // NOTE: clocked state uses non-blocking assignment so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_comet_sequencer.sv
// -----------------------------------------------------------------------------
// led_comet_sequencer
//   Duty-pattern source for the per-LED PWM stage. A full-brightness head walks
//   along the bar and leaves a geometrically decaying tail. Each animation
//   step the working frame is decayed one channel per cycle, the head is
//   advanced and stamped at DUTY_MAX, and the finished frame is published to
//   duty_flat in a single update so downstream never sees a partial frame.
//
//   Ports
//     CLOCK_50     in   sole clock
//     RESET        in   synchronous active-high reset; aborts a frame in flight
//     enable       in   1 = animate, 0 = freeze divider (a frame in flight
//                       still completes)
//     wrap_mode    in   0 = bounce at ends, 1 = wrap last -> 0; sampled in HEAD
//     duty_flat    out  channel i at [i*DUTY_W +: DUTY_W], registered
//     head_pos     out  current head index
//     dir_down     out  0 = head moving up, 1 = moving down
//     step_strobe  out  1-cycle pulse in the cycle duty_flat changes
//
//   Timing: tick in cycle t -> pending at t+1 -> DECAY t+2..t+NUM_LEDS+1 ->
//   HEAD t+NUM_LEDS+2 -> PUBLISH t+NUM_LEDS+3. The publish registers are loaded
//   on the HEAD->PUBLISH edge, so the new frame and the strobe are both visible
//   during the PUBLISH cycle.
// -----------------------------------------------------------------------------
module led_comet_sequencer
  import led_pkg::*;
#(
  parameter int STEP_DIV    = 2500000,  // must be >= NUM_LEDS+4
  parameter int DECAY_SHIFT = 1
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET,
  input  logic                       enable,
  input  logic                       wrap_mode,
  output logic [NUM_LEDS*DUTY_W-1:0] duty_flat,
  output logic [HEAD_W-1:0]          head_pos,
  output logic                       dir_down,
  output logic                       step_strobe
);

  logic       tick;

  state_e     state_q;
  head_t      idx_q;
  logic       pending_q;
  frame_t     work_q;
  frame_t     duty_q;
  head_t      head_q;
  logic       dir_q;
  logic       strobe_q;

  head_step_t adv_d;
  frame_t     frame_d;
  duty_t      decay_d;

  step_divider #(
    .STEP_DIV (STEP_DIV)
  ) u_step_divider (
    .clk_i    (CLOCK_50),
    .rst_i    (RESET),
    .enable_i (enable),
    .tick_o   (tick)
  );

  // Next head position and the completed frame with the new head stamped in.
  // frame_d is what both the working array and the publish register take in
  // HEAD, which is why the published frame already contains the head.
  always_comb begin
    adv_d            = next_head(head_q, dir_q, wrap_mode);
    frame_d          = work_q;
    frame_d[adv_d.head] = DUTY_MAX;
    decay_d          = work_q[idx_q] >> DECAY_SHIFT;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      // NOTE: the working array is reset along with everything else; the tail
      // is built from its previous contents, so garbage there would be visible.
      work_q    <= '0;
      duty_q    <= '0;
      head_q    <= '0;
      dir_q     <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;

      // A tick on top of an outstanding request is dropped.
      if (tick && !pending_q) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            state_q   <= ST_DECAY;
            idx_q     <= '0;
            pending_q <= 1'b0;
          end
        end

        ST_DECAY: begin
          work_q[idx_q] <= decay_d;
          if (idx_q == HEAD_LAST) begin
            state_q <= ST_HEAD;
          end else begin
            idx_q <= idx_q + head_t'(1);
          end
        end

        ST_HEAD: begin
          head_q   <= adv_d.head;
          dir_q    <= adv_d.dir_down;
          work_q   <= frame_d;
          duty_q   <= frame_d;
          strobe_q <= 1'b1;
          state_q  <= ST_PUBLISH;
        end

        ST_PUBLISH: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign duty_flat   = pack_frame(duty_q);
  assign head_pos    = head_q;
  assign dir_down    = dir_q;
  assign step_strobe = strobe_q;

endmodule
